// File: rtl/n64_pkg.sv
// n64_pkg: shared definitions for the N64 Joybus response decoder.
// Holds the decoder state encoding, the err_code values and the
// microsecond multipliers used for the bit-value and low-abort thresholds.
package n64_pkg;

  // Decoder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_LOW        = 3'd2,
    ST_HIGH       = 3'd3,
    ST_STOP       = 3'd4
  } state_t;

  // Abort causes reported on err_code.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_LOW_LONG = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_SHORT    = 2'b11;

  // A low phase shorter than BIT_ONE_MULT us decodes as a 1.
  localparam int BIT_ONE_MULT   = 2;
  // A low phase lasting LOW_ABORT_MULT us or more is a broken frame.
  localparam int LOW_ABORT_MULT = 4;

  // Microseconds to clock ticks.
  function automatic int us_to_ticks(input int us, input int ticks_per_us);
    return us * ticks_per_us;
  endfunction

endpackage

// File: rtl/n64_line_sync.sv
// n64_line_sync: brings the asynchronous Joybus line into the clk domain
// and flags edges on the synchronised level.
// Ports: clk, rst_n (async active-low), line_in (raw line),
//        line_s (synchronised level), fall / rise (one-cycle edge strobes).
module n64_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_s,
  output logic fall,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // All three flops come out of reset high, matching the idle line, so
  // releasing reset never manufactures a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign line_s = sync;
  assign fall   = prev & ~sync;
  assign rise   = ~prev & sync;

endmodule

// File: rtl/n64_resp_decoder.sv
// n64_resp_decoder: decodes one Joybus response frame (NUM_BITS data bits,
// MSB first, followed by a stop bit) after each arm pulse.
// Ports: clk, Reset (async active-low), arm (start listening), line_in (raw
//        line), data_out (last good frame), data_valid / frame_err (one-cycle
//        completion pulses), err_code (abort cause, held until next arm),
//        busy (a response is being listened for).
module n64_resp_decoder #(
  parameter int TICKS_PER_US = 14,
  parameter int NUM_BITS     = 32,
  parameter int TIMEOUT_US   = 8
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                arm,
  input  logic                line_in,
  output logic [NUM_BITS-1:0] data_out,
  output logic                data_valid,
  output logic                frame_err,
  output logic [1:0]          err_code,
  output logic                busy
);

  import n64_pkg::*;

  localparam int TIMEOUT_TICKS = us_to_ticks(TIMEOUT_US, TICKS_PER_US);
  localparam int CNT_W         = $clog2(TIMEOUT_TICKS + 1);
  localparam int BIT_CNT_W     = $clog2(NUM_BITS + 1);

  localparam logic [CNT_W-1:0]     CNT_MAX       = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     TIMEOUT_LIM   = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0]     ONE_LIM       = CNT_W'(BIT_ONE_MULT * TICKS_PER_US);
  localparam logic [CNT_W-1:0]     LOW_ABORT_LIM = CNT_W'(LOW_ABORT_MULT * TICKS_PER_US);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_FULL  = BIT_CNT_W'(NUM_BITS);

  // --------------------------------------------------------------------
  // Line synchroniser and edge detector
  // --------------------------------------------------------------------
  logic line_s;
  logic fall;
  logic rise;

  n64_line_sync u_line_sync (
    .clk     (clk),
    .rst_n   (Reset),
    .line_in (line_in),
    .line_s  (line_s),
    .fall    (fall),
    .rise    (rise)
  );

  // --------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------
  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_d;
  logic [NUM_BITS-1:0]    shreg_q;
  logic [NUM_BITS-1:0]    shreg_d;
  logic [NUM_BITS-1:0]    data_d;
  logic                   valid_d;
  logic                   err_pulse_d;
  logic [1:0]             err_code_d;
  logic                   bit_val;

  // The counter holds the number of cycles already spent in the current
  // phase; cnt_inc includes the present cycle, so every threshold below is
  // compared against the full length of the phase so far.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Short low means 1; exactly the threshold already counts as 0.
  assign bit_val = (cnt_inc < ONE_LIM);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_out;
    valid_d     = 1'b0;
    err_pulse_d = 1'b0;
    err_code_d  = err_code;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (arm) begin
          state_d    = ST_WAIT_START;
          bit_cnt_d  = '0;
          shreg_d    = '0;
          err_code_d = ERR_NONE;
        end
      end

      ST_WAIT_START: begin
        if (cnt_inc >= TIMEOUT_LIM) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end else if (fall) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      end

      ST_LOW: begin
        // The overlong-low abort wins over a simultaneous return high.
        // LOW is only entered on a fall, so a high synchronised level here
        // is exactly the rising edge that ends the bit cell.
        if (cnt_inc >= LOW_ABORT_LIM) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_LOW_LONG;
        end else if (line_s) begin
          state_d   = ST_HIGH;
          cnt_d     = '0;
          shreg_d   = (shreg_q << 1) | NUM_BITS'(bit_val);
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end

      ST_HIGH: begin
        if (cnt_inc >= TIMEOUT_LIM) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          err_pulse_d = 1'b1;
          err_code_d  = (bit_cnt_q != '0) ? ERR_SHORT : ERR_TIMEOUT;
        end else if (fall) begin
          state_d = (bit_cnt_q == BIT_CNT_FULL) ? ST_STOP : ST_LOW;
          cnt_d   = '0;
        end
      end

      ST_STOP: begin
        if (cnt_inc >= LOW_ABORT_LIM) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_LOW_LONG;
        end else if (rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          data_d  = shreg_q;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      frame_err  <= err_pulse_d;
      err_code   <= err_code_d;
    end
  end

  // Completion pulses coincide with the return to IDLE, so busy drops in
  // the same cycle data_valid or frame_err is seen.
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_n64_resp_decoder.sv
module tb_n64_resp_decoder;

  localparam int TPU     = 14;
  localparam int TO_TCK  = 8 * TPU;   // 112
  localparam int ONE_TCK = 2 * TPU;   // 28
  localparam int ABT_TCK = 4 * TPU;   // 56

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        arm_a, arm_b, line_a, line_b;
  logic [31:0] data_a;
  logic [7:0]  data_b;
  logic        dv_a, dv_b, fe_a, fe_b, busy_a, busy_b;
  logic [1:0]  err_a, err_b;

  n64_resp_decoder #(.TICKS_PER_US(14), .NUM_BITS(32), .TIMEOUT_US(8)) dut_a (
    .clk(clk), .Reset(rst_n), .arm(arm_a), .line_in(line_a),
    .data_out(data_a), .data_valid(dv_a), .frame_err(fe_a),
    .err_code(err_a), .busy(busy_a)
  );

  n64_resp_decoder #(.TICKS_PER_US(14), .NUM_BITS(8), .TIMEOUT_US(8)) dut_b (
    .clk(clk), .Reset(rst_n), .arm(arm_b), .line_in(line_b),
    .data_out(data_b), .data_valid(dv_b), .frame_err(fe_b),
    .err_code(err_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  // Pulse counters, sampled away from the active edge.
  int dv_cnt_a = 0, dv_cnt_b = 0, fe_cnt_a = 0, fe_cnt_b = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (dv_a) dv_cnt_a++;
    if (dv_b) dv_cnt_b++;
    if (fe_a) fe_cnt_a++;
    if (fe_b) fe_cnt_b++;
    if ((dv_a && fe_a) || (dv_b && fe_b)) both_cnt++;
  end

  // Frame description: per-bit low and following high durations in cycles.
  int lo[32];
  int hi[32];
  int stop_lo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) line_a = v; else line_b = v;
  endtask

  task automatic set_arm(input int sel, input logic v);
    if (sel == 0) arm_a = v; else arm_b = v;
  endtask

  function automatic logic [31:0] cur_data(input int sel);
    return (sel == 0) ? data_a : {24'h0, data_b};
  endfunction
  function automatic logic [31:0] cur_err(input int sel);
    return (sel == 0) ? {30'h0, err_a} : {30'h0, err_b};
  endfunction
  function automatic logic [31:0] cur_busy(input int sel);
    return (sel == 0) ? {31'h0, busy_a} : {31'h0, busy_b};
  endfunction
  function automatic int dv_count(input int sel);
    return (sel == 0) ? dv_cnt_a : dv_cnt_b;
  endfunction
  function automatic int fe_count(input int sel);
    return (sel == 0) ? fe_cnt_a : fe_cnt_b;
  endfunction

  // Reference model: walk the frame phase by phase using the protocol rules.
  function automatic void model(input int nb, output bit ok, output logic [1:0] ec,
                                output logic [31:0] d);
    d  = 32'h0;
    ok = 1'b0;
    ec = 2'b00;
    for (int i = 0; i < nb; i++) begin
      if (lo[i] >= ABT_TCK) begin ec = 2'b01; return; end
      d = (d << 1) | ((lo[i] < ONE_TCK) ? 32'd1 : 32'd0);
      if (hi[i] >= TO_TCK) begin ec = 2'b11; return; end
    end
    if (stop_lo >= ABT_TCK) begin ec = 2'b01; return; end
    ok = 1'b1;
  endfunction

  task automatic fill_nominal(input logic [31:0] v, input int nb);
    for (int i = 0; i < nb; i++) begin
      if (v[nb-1-i]) begin lo[i] = TPU; hi[i] = 3 * TPU; end
      else           begin lo[i] = 3 * TPU; hi[i] = TPU; end
    end
    stop_lo = 2 * TPU;
  endtask

  task automatic fill_random(input int nb);
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 1) == 1) lo[i] = $urandom_range(5, ONE_TCK - 1);
      else                           lo[i] = $urandom_range(ONE_TCK, ABT_TCK - 2);
      hi[i] = $urandom_range(5, 100);
    end
    stop_lo = $urandom_range(5, ABT_TCK - 2);
  endtask

  task automatic drive_frame(input int sel, input int nb);
    for (int i = 0; i < nb; i++) begin
      set_line(sel, 1'b0);
      repeat (lo[i]) @(negedge clk);
      set_line(sel, 1'b1);
      repeat (hi[i]) @(negedge clk);
    end
    set_line(sel, 1'b0);
    repeat (stop_lo) @(negedge clk);
    set_line(sel, 1'b1);
  endtask

  task automatic run_frame(input int sel, input int nb, input string tag);
    int          dv0, fe0;
    logic [31:0] prev, d;
    logic [1:0]  ec;
    bit          ok, got;
    prev = cur_data(sel);
    dv0  = dv_count(sel);
    fe0  = fe_count(sel);
    model(nb, ok, ec, d);
    @(negedge clk);
    set_arm(sel, 1'b1);
    @(negedge clk);
    set_arm(sel, 1'b0);
    check({tag, "_busy_after_arm"}, cur_busy(sel), 32'd1);
    check({tag, "_err_cleared_on_arm"}, cur_err(sel), 32'd0);
    drive_frame(sel, nb);
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (dv_count(sel) != dv0 || fe_count(sel) != fe0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_completed"}, {31'h0, got}, 32'd1);
    repeat (4) @(negedge clk);
    check({tag, "_dv_pulses"}, dv_count(sel) - dv0, ok ? 32'd1 : 32'd0);
    check({tag, "_fe_pulses"}, fe_count(sel) - fe0, ok ? 32'd0 : 32'd1);
    check({tag, "_err_code"}, cur_err(sel), ok ? 32'd0 : {30'h0, ec});
    check({tag, "_data_out"}, cur_data(sel), ok ? d : prev);
    check({tag, "_busy_end"}, cur_busy(sel), 32'd0);
  endtask

  initial begin
    int          n, fe_snap, pos;
    bit          got, busy_pre;
    logic [31:0] snap;

    rst_n = 1'b0; arm_a = 1'b0; arm_b = 1'b0; line_a = 1'b1; line_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_a", data_a, 32'h0);
    check("rst_data_b", {24'h0, data_b}, 32'h0);
    check("rst_dv_fe", {30'h0, dv_a | dv_b, fe_a | fe_b}, 32'h0);
    check("rst_err", {28'h0, err_a, err_b}, 32'h0);
    check("rst_busy", {30'h0, busy_a, busy_b}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_false_edge_after_rst", {30'h0, busy_a, fe_a}, 32'h0);

    // Armed with the line idle: timeout 112 cycles after arm is accepted.
    // A second arm while waiting must not restart the wait.
    arm_a = 1'b1;
    @(negedge clk);
    arm_a = 1'b0;
    n = 0; got = 1'b0; busy_pre = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      arm_a = (k == 50);
      if (k == 111) busy_pre = busy_a;
      if (fe_a) begin n = k; got = 1'b1; break; end
    end
    arm_a = 1'b0;
    check("idle_timeout_seen", {31'h0, got}, 32'd1);
    check("idle_timeout_cycles", n, 32'd112);
    check("idle_timeout_busy_before", {31'h0, busy_pre}, 32'd1);
    check("idle_timeout_busy_after", {31'h0, busy_a}, 32'd0);
    check("idle_timeout_err", {30'h0, err_a}, 32'h2);
    repeat (20) @(negedge clk);
    check("err_code_held", {30'h0, err_a}, 32'h2);

    // Nominal frame.
    fill_nominal(32'h8000_1234, 32);
    run_frame(0, 32, "nominal");
    check("nominal_value", data_a, 32'h8000_1234);

    // Thresholds: 27 -> 1, 28 -> 0, 55 -> 0, high of 111 and stop of 55 still legal.
    fill_nominal(32'h0F0F_5A5A, 32);
    lo[0] = 27; lo[1] = 28; lo[2] = 55; hi[5] = 111; stop_lo = 55;
    run_frame(0, 32, "thresh");
    snap = data_a;
    check("thresh_top_bits", {29'h0, snap[31:29]}, 32'h4);

    // 5 us low in the middle of a frame.
    fill_nominal(32'hDEAD_BEEF, 32);
    lo[10] = 5 * TPU;
    run_frame(0, 32, "low_5us");
    check("low_5us_data_kept", data_a, snap);

    // Exactly 4 us low in the stop bit aborts.
    fill_nominal(32'h1357_9BDF, 32);
    stop_lo = ABT_TCK;
    run_frame(0, 32, "stop_long");

    // 20 bits, then the line stays high.
    fill_nominal(32'hCAFE_F00D, 32);
    hi[19] = 200;
    run_frame(0, 32, "short_frame");
    check("short_frame_err", {30'h0, err_a}, 32'h3);

    // Random frames on both decoders, with a couple of random aborts.
    for (int r = 0; r < 5; r++) begin
      fill_random(32);
      run_frame(0, 32, "rand32");
    end
    for (int r = 0; r < 2; r++) begin
      fill_random(32);
      pos = $urandom_range(0, 31);
      if (r == 0) lo[pos] = $urandom_range(ABT_TCK, ABT_TCK + 15);
      else        hi[pos] = $urandom_range(TO_TCK, TO_TCK + 15);
      run_frame(0, 32, "rand32_err");
    end

    fill_nominal(32'h0000_00A5, 8);
    run_frame(1, 8, "nb8_a5");
    check("nb8_a5_value", {24'h0, data_b}, 32'hA5);
    for (int r = 0; r < 3; r++) begin
      fill_random(8);
      run_frame(1, 8, "rand8");
    end

    // Reset in the middle of a frame.
    fe_snap = fe_cnt_a;
    fill_nominal(32'h7777_1111, 32);
    @(negedge clk); arm_a = 1'b1;
    @(negedge clk); arm_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      line_a = 1'b0; repeat (lo[i]) @(negedge clk);
      line_a = 1'b1; repeat (hi[i]) @(negedge clk);
    end
    line_a = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_busy_before", {31'h0, busy_a}, 32'd1);
    rst_n = 1'b0;
    line_a = 1'b1;
    #1;
    check("midrst_data", data_a, 32'h0);
    check("midrst_data_b", {24'h0, data_b}, 32'h0);
    check("midrst_flags", {28'h0, dv_a, fe_a, busy_a, busy_b}, 32'h0);
    check("midrst_err", {28'h0, err_a, err_b}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_frame_err", fe_cnt_a - fe_snap, 32'd0);
    check("midrst_idle_after", {31'h0, busy_a}, 32'd0);

    fill_random(32);
    run_frame(0, 32, "after_rst");

    check("dv_fe_never_together", both_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
